// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - two-source round-robin framer in front of a UART byte transmitter
//
// Purpose: arbitrates two 64-bit word sources onto one UART TX byte engine. The granted
// word is sent as a 10-byte frame: header (HDR_BASE | src), 8 data bytes LSB-first,
// XOR checksum of the previous nine bytes. Every byte waits for tx_done, guarded by a
// watchdog; a stalled byte aborts the frame.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_a/req_b         source word pending, held until the matching ack
//   data_a/data_b       source words, sampled only at grant
//   ack_a/ack_b         1-cycle pulse when the source's frame completed
//   tx_data, tx_start   byte to the transmitter and its 1-cycle load strobe
//   tx_done             1-cycle pulse from the transmitter, byte finished
//   busy                frame in progress
//   grant_src           current/last granted source (0=A, 1=B)
//   err                 1-cycle pulse on byte timeout (frame aborted)
//   frame_cnt           completed frames, wraps at 16 bits

module uart_frame_arbiter #(
  parameter int unsigned CLK_F      = 50_000_000,
  parameter int unsigned UART_BPS   = 115200,
  parameter logic [7:0]  HDR_BASE   = 8'hA0,
  parameter int unsigned TX_TIMEOUT = 12 * (CLK_F / UART_BPS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [63:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [63:0] data_b,
  output logic        ack_b,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        grant_src,
  output logic        err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned   TW         = $clog2(TX_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TX_TIMEOUT - 1);
  localparam logic [3:0]    IDX_DATA_LAST = 4'd8;
  localparam logic [3:0]    IDX_CSUM      = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [63:0]     shreg;
  logic [3:0]      idx;
  logic [7:0]      csum;
  logic [TW-1:0]   timer;
  logic            last_grant;
  logic            pick_b;
  logic            timeout;
  logic [7:0]      hdr_byte;

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    busy       = 1'b1;
    ack_a      = 1'b0;
    ack_b      = 1'b0;
    err        = 1'b0;

    // Single requester wins outright; on a tie the source that did not go last wins.
    pick_b   = req_b && (!req_a || !last_grant);
    hdr_byte = HDR_BASE | {7'b0, pick_b};
    timeout  = (state == S_WAIT) && (timer == TIMER_LAST);

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req_a || req_b) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        tx_start   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_next = (idx == IDX_CSUM) ? S_DONE : S_ISSUE;
        end else if (timeout) begin
          // err fires on the last cycle a tx_done would still have been accepted,
          // i.e. exactly TX_TIMEOUT cycles after the byte's tx_start.
          err        = 1'b1;
          state_next = S_ABORT;
        end
      end
      S_DONE: begin
        ack_a      = !grant_src;
        ack_b      = grant_src;
        state_next = S_IDLE;
      end
      S_ABORT: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // tx_data is loaded on entry to ISSUE so it is already valid while tx_start is high
  // and stays put through WAIT. csum accumulates each of bytes 0..8 as it is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      idx        <= '0;
      csum       <= '0;
      timer      <= '0;
      last_grant <= 1'b1;
      grant_src  <= 1'b0;
      tx_data    <= '0;
      frame_cnt  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_a || req_b) begin
            grant_src <= pick_b;
            shreg     <= pick_b ? data_b : data_a;
            idx       <= '0;
            tx_data   <= hdr_byte;
            csum      <= hdr_byte;
          end
        end
        S_ISSUE: begin
          timer <= '0;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (tx_done && (idx != IDX_CSUM)) begin
            idx <= idx + 4'd1;
            if (idx == IDX_DATA_LAST) begin
              tx_data <= csum;
            end else begin
              tx_data <= shreg[7:0];
              csum    <= csum ^ shreg[7:0];
              shreg   <= {8'h00, shreg[63:8]};
            end
          end
        end
        S_DONE: begin
          frame_cnt  <= frame_cnt + 16'd1;
          last_grant <= grant_src;
        end
        S_ABORT: begin
          last_grant <= grant_src;
        end
        default: ;
      endcase
    end
  end

endmodule
